// File: rtl/vga_scanout_arbiter.sv
// Single-port framebuffer arbiter: scanout prefetch into a 2-word FIFO has strict
// priority, pixels are serialised at 8bpp, and every other RAM slot goes to the CPU.
module vga_scanout_arbiter #(
  parameter int X_ACTIVE = 800,
  parameter int Y_ACTIVE = 600,
  parameter int ADDR_W   = 17,
  parameter int FB_BASE  = 0
) (
  input  logic              pixel_clock,
  input  logic              reset_n,
  input  logic [15:0]       x,
  input  logic [15:0]       y,
  input  logic              xy_in_active,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              blank_in,
  output logic              hsync,
  output logic              vsync,
  output logic              blank,
  output logic [7:0]        pixel,
  output logic              underrun,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [3:0]        cpu_we,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int FRAME_WORDS = (X_ACTIVE / 4) * Y_ACTIVE;
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(FB_BASE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_BASE + FRAME_WORDS - 1);

  logic              vb;
  logic              vb_q;
  logic              resync;
  logic              sreq;
  logic              scan_pend;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [1:0]        fifo_count;
  logic [1:0]        byte_idx;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [31:0]       fifo_mem [2];
  logic [31:0]       head;
  logic [31:0]       rdata_q;
  logic [ADDR_W-1:0] fetch_addr;
  logic              unused_x;

  // Scanout address comes from fetch_addr, so the x coordinate is not needed.
  assign unused_x   = ^x;

  assign vb         = (y >= 16'(Y_ACTIVE));
  assign resync     = vb && !vb_q;
  assign sreq       = ((fifo_count + {1'b0, scan_pend}) < 2'd2) && !resync;
  assign fifo_empty = (fifo_count == 2'd0);
  assign head       = fifo_mem[rd_ptr];
  // A scanout read returning during resync belongs to the old frame and is dropped.
  assign push       = scan_pend && !resync;
  assign pop        = xy_in_active && !fifo_empty && (byte_idx == 2'd3) && !resync;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = fetch_addr;
    mem_wdata = 32'h0;
    cpu_ready = 1'b0;
    if (sreq) begin
      mem_en = 1'b1;
    end else begin
      cpu_ready = 1'b1;
      mem_en    = cpu_valid;
      mem_we    = cpu_valid ? cpu_we : 4'b0000;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  // Read data is presented straight from the RAM on the response cycle, then held.
  assign cpu_rdata = cpu_rvalid ? mem_rdata : rdata_q;

  always_ff @(posedge pixel_clock) begin
    if (push) fifo_mem[wr_ptr] <= mem_rdata;
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      vb_q       <= 1'b0;
      scan_pend  <= 1'b0;
      cpu_rvalid <= 1'b0;
      rdata_q    <= 32'h0;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      blank      <= 1'b0;
      pixel      <= 8'h00;
      underrun   <= 1'b0;
      fetch_addr <= BASE_ADDR;
      fifo_count <= 2'd0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      byte_idx   <= 2'd0;
    end else begin
      vb_q       <= vb;
      scan_pend  <= sreq;
      cpu_rvalid <= cpu_valid && !sreq && (cpu_we == 4'b0000);
      if (cpu_rvalid) rdata_q <= mem_rdata;
      hsync      <= hsync_in;
      vsync      <= vsync_in;
      blank      <= blank_in;

      if (resync)
        fetch_addr <= BASE_ADDR;
      else if (sreq)
        fetch_addr <= (fetch_addr == LAST_ADDR) ? BASE_ADDR : fetch_addr + ADDR_W'(1);

      if (resync) begin
        fifo_count <= 2'd0;
        wr_ptr     <= 1'b0;
        rd_ptr     <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        case ({push, pop})
          2'b10:   fifo_count <= fifo_count + 2'd1;
          2'b01:   fifo_count <= fifo_count - 2'd1;
          default: fifo_count <= fifo_count;
        endcase
      end

      pixel <= 8'h00;
      if (xy_in_active) begin
        if (fifo_empty) underrun <= 1'b1;
        else            pixel    <= head[{byte_idx, 3'b000} +: 8];
      end

      // byte_idx keeps stepping on underrun; alignment returns at the next resync.
      if (resync)
        byte_idx <= 2'd0;
      else if (xy_in_active)
        byte_idx <= byte_idx + 2'd1;
    end
  end

endmodule

// File: tb/tb_vga_scanout_arbiter.sv
// Directed bench for vga_scanout_arbiter on a reduced 32x8 frame with a 1-cycle RAM model.
module tb_vga_scanout_arbiter;

  localparam int XA   = 32;
  localparam int YA   = 8;
  localparam int AW   = 17;
  localparam int BASE = 64;
  localparam int FW   = XA / 4 * YA;
  localparam int HT   = 40;
  localparam int VT   = YA + 3;

  logic          pixel_clock = 1'b0;
  logic          reset_n;
  logic [15:0]   x, y;
  logic          xy_in_active, hsync_in, vsync_in, blank_in;
  logic          hsync, vsync, blank;
  logic [7:0]    pixel;
  logic          underrun;
  logic          cpu_valid, cpu_ready;
  logic [AW-1:0] cpu_addr;
  logic [3:0]    cpu_we;
  logic [31:0]   cpu_wdata, cpu_rdata;
  logic          cpu_rvalid;
  logic [AW-1:0] mem_addr;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [31:0]   mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] init_ram [0:255];
  logic [31:0] wram [0:255];
  logic        wvalid [0:255];
  logic [31:0] wtmp;

  always #5 pixel_clock = ~pixel_clock;

  vga_scanout_arbiter #(.X_ACTIVE(XA), .Y_ACTIVE(YA), .ADDR_W(AW), .FB_BASE(BASE)) dut (
    .pixel_clock(pixel_clock), .reset_n(reset_n), .x(x), .y(y), .xy_in_active(xy_in_active),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
    .hsync(hsync), .vsync(vsync), .blank(blank), .pixel(pixel), .underrun(underrun),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // RAM model: preloaded image in init_ram, CPU writes overlay it in wram.
  always @(posedge pixel_clock) begin
    if (!reset_n) begin
      mem_rdata <= 32'h0;
      for (int i = 0; i < 256; i++) wvalid[i] <= 1'b0;
    end else if (mem_en) begin
      wtmp = wvalid[mem_addr[7:0]] ? wram[mem_addr[7:0]] : init_ram[mem_addr[7:0]];
      if (mem_we == 4'b0000) begin
        mem_rdata <= wtmp;
      end else begin
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) wtmp[8*b +: 8] = mem_wdata[8*b +: 8];
        wram[mem_addr[7:0]]   <= wtmp;
        wvalid[mem_addr[7:0]] <= 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge pixel_clock);
    #1;
  endtask

  task automatic sample();
    @(negedge pixel_clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; y = 16'(YA); x = 16'd0; xy_in_active = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; blank_in = 1'b1;
    cpu_valid = 1'b0; cpu_we = 4'b0; cpu_addr = '0; cpu_wdata = 32'h0;
    repeat (3) @(posedge pixel_clock);
    sample();
    checks++;
    if ({pixel, hsync, vsync, blank, underrun, cpu_rvalid} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs got pixel=%h h=%b v=%b b=%b ur=%b rv=%b exp all 0",
               pixel, hsync, vsync, blank, underrun, cpu_rvalid);
    end
    checks++;
    if (cpu_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got %h exp 00000000", cpu_rdata);
    end
  endtask

  task automatic test_resync_prefetch();
    logic ee [4];
    int   ea [4];
    ee = '{1'b1, 1'b1, 1'b0, 1'b0};
    ea = '{BASE, BASE + 1, 0, 0};
    step();
    reset_n = 1'b1;
    sample();
    checks++;
    if (mem_en !== 1'b0 || cpu_ready !== 1'b1) begin
      errors++;
      $display("FAIL resync_no_fetch got mem_en=%b cpu_ready=%b exp 0 1", mem_en, cpu_ready);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      sample();
      checks++;
      if (mem_en !== ee[i] || (ee[i] && (mem_addr !== AW'(ea[i]) || mem_we !== 4'b0))) begin
        errors++;
        $display("FAIL prefetch_%0d got en=%b addr=%h we=%h exp en=%b addr=%h", i, mem_en,
                 mem_addr, mem_we, ee[i], AW'(ea[i]));
      end
      if (i == 0) begin
        checks++;
        if ({hsync, vsync, blank} !== 3'b111) begin
          errors++;
          $display("FAIL sync_delay_hi got %b exp 111", {hsync, vsync, blank});
        end
        hsync_in = 1'b0; vsync_in = 1'b0; blank_in = 1'b0;
      end
      if (i == 2) begin
        checks++;
        if ({hsync, vsync, blank} !== 3'b000) begin
          errors++;
          $display("FAIL sync_delay_lo got %b exp 000", {hsync, vsync, blank});
        end
      end
    end
  endtask

  task automatic test_pixel_serialise();
    logic [7:0] ep [10];
    logic       me [10];
    ep = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
    me = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      step();
      y = 16'd0;
      xy_in_active = (i < 8);
      sample();
      checks++;
      if (pixel !== ep[i]) begin
        errors++;
        $display("FAIL pixel_%0d got %h exp %h", i, pixel, ep[i]);
      end
      checks++;
      if (mem_en !== me[i] || (i == 4 && mem_addr !== AW'(BASE + 2)) ||
          (i == 8 && mem_addr !== AW'(BASE + 3))) begin
        errors++;
        $display("FAIL refill_%0d got en=%b addr=%h exp en=%b", i, mem_en, mem_addr, me[i]);
      end
    end
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL no_underrun got %b exp 0", underrun);
    end
  endtask

  task automatic test_cpu_access();
    for (int i = 0; i < 4; i++) begin
      step();
      xy_in_active = 1'b1;
      sample();
    end
    step();
    xy_in_active = 1'b0; cpu_valid = 1'b1; cpu_we = 4'hF; cpu_addr = AW'(5);
    cpu_wdata = 32'hDEADBEEF;
    sample();
    checks++;
    if (cpu_ready !== 1'b0 || mem_en !== 1'b1 || mem_we !== 4'h0 || mem_addr !== AW'(BASE + 4)) begin
      errors++;
      $display("FAIL sreq_blocks_cpu got ready=%b en=%b we=%h addr=%h exp 0 1 0 %h",
               cpu_ready, mem_en, mem_we, mem_addr, AW'(BASE + 4));
    end
    step();
    sample();
    checks++;
    if (cpu_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 4'hF || mem_addr !== AW'(5) ||
        mem_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL cpu_write_grant got ready=%b en=%b we=%h addr=%h wd=%h exp 1 1 f 5 deadbeef",
               cpu_ready, mem_en, mem_we, mem_addr, mem_wdata);
    end
    step();
    cpu_we = 4'h0;
    sample();
    checks++;
    if (cpu_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 4'h0 || mem_addr !== AW'(5)) begin
      errors++;
      $display("FAIL cpu_read_grant got ready=%b en=%b we=%h addr=%h exp 1 1 0 5",
               cpu_ready, mem_en, mem_we, mem_addr);
    end
    checks++;
    if (cpu_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL write_no_resp got rvalid=%b exp 0", cpu_rvalid);
    end
    step();
    cpu_valid = 1'b0;
    sample();
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL cpu_read_resp got rvalid=%b rdata=%h exp 1 deadbeef", cpu_rvalid, cpu_rdata);
    end
    step();
    sample();
    checks++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL cpu_rdata_hold got rvalid=%b rdata=%h exp 0 deadbeef", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_full_frame();
    int         exp_addr, grants, act_cycles, prev_x, prev_y;
    bit         prev_act, prev_vb, prev_grant, wrap_seen, at_last;
    logic [2:0] prev_sync;
    logic [7:0] exp_pix;
    for (int i = 0; i < FW; i++)
      init_ram[BASE + i] = {8'(4*i + 3) ^ 8'hA5, 8'(4*i + 2) ^ 8'hA5,
                            8'(4*i + 1) ^ 8'hA5, 8'(4*i) ^ 8'hA5};
    exp_addr = BASE; grants = 0; act_cycles = 0; prev_x = 0; prev_y = 0;
    prev_act = 0; prev_vb = 0; prev_grant = 0; wrap_seen = 0; at_last = 0; prev_sync = 3'b000;
    for (int f = 0; f < 2; f++) begin
      for (int ln = 0; ln < VT; ln++) begin
        for (int xx = 0; xx < HT; xx++) begin
          int yy;
          bit act, vb;
          yy  = (ln < 3) ? YA + ln : ln - 3;
          act = (yy < YA) && (xx < XA);
          vb  = (yy >= YA);
          step();
          y = 16'(yy); x = 16'(xx); xy_in_active = act;
          hsync_in = (xx >= 34 && xx < 38); vsync_in = (yy == YA + 1); blank_in = !act;
          cpu_valid = 1'b1; cpu_we = 4'h0; cpu_addr = AW'(5);
          sample();
          if (vb && !prev_vb) begin
            checks++;
            if (cpu_ready !== 1'b1) begin
              errors++;
              $display("FAIL frame_resync_idle f%0d got ready=%b exp 1", f, cpu_ready);
            end
            exp_addr = BASE;
            at_last  = 0;
          end else if (cpu_ready === 1'b0) begin
            checks++;
            if (mem_en !== 1'b1 || mem_we !== 4'h0 || mem_addr !== AW'(exp_addr)) begin
              errors++;
              $display("FAIL scan_addr f%0d y%0d x%0d got en=%b addr=%h exp %h", f, yy, xx,
                       mem_en, mem_addr, AW'(exp_addr));
            end else if (at_last && exp_addr == BASE) begin
              wrap_seen = 1;
            end
            at_last  = (exp_addr == BASE + FW - 1);
            exp_addr = at_last ? BASE : exp_addr + 1;
          end
          exp_pix = prev_act ? (8'(prev_y * XA + prev_x) ^ 8'hA5) : 8'h00;
          checks++;
          if (pixel !== exp_pix) begin
            errors++;
            $display("FAIL frame_pixel f%0d y%0d x%0d got %h exp %h", f, prev_y, prev_x, pixel, exp_pix);
          end
          checks++;
          if ({hsync, vsync, blank} !== prev_sync) begin
            errors++;
            $display("FAIL frame_sync f%0d y%0d x%0d got %b exp %b", f, yy, xx,
                     {hsync, vsync, blank}, prev_sync);
          end
          checks++;
          if (prev_grant ? (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) : (cpu_rvalid !== 1'b0)) begin
            errors++;
            $display("FAIL frame_cpu_resp f%0d y%0d x%0d got rvalid=%b rdata=%h exp rvalid=%b",
                     f, yy, xx, cpu_rvalid, cpu_rdata, prev_grant);
          end
          if (act) begin
            act_cycles++;
            if (cpu_ready === 1'b1) grants++;
          end
          prev_act = act; prev_x = xx; prev_y = yy; prev_vb = vb;
          prev_grant = (cpu_ready === 1'b1);
          prev_sync  = {hsync_in, vsync_in, blank_in};
        end
      end
    end
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL frame_underrun got %b exp 0", underrun);
    end
    checks++;
    if (grants * 4 < act_cycles * 3) begin
      errors++;
      $display("FAIL cpu_share got %0d of %0d active cycles exp at least 75%%", grants, act_cycles);
    end
    checks++;
    if (!wrap_seen) begin
      errors++;
      $display("FAIL fetch_wrap got no wrap exp fetch to %h after %h", AW'(BASE), AW'(BASE + FW - 1));
    end
  endtask

  task automatic test_resync_inflight();
    bit act, me;
    int ma;
    cpu_valid = 1'b0;
    for (int i = 0; i < 14; i++) begin
      act = (i >= 2 && i <= 5) || i == 11 || i == 12;
      me  = (i == 6 || i == 8 || i == 9);
      ma  = (i == 6) ? BASE + 2 : (i == 8) ? BASE : BASE + 1;
      step();
      y = (i >= 7 && i <= 10) ? 16'(YA) : 16'd0;
      x = 16'd0; xy_in_active = act; blank_in = !act;
      hsync_in = 1'b0; vsync_in = 1'b0;
      sample();
      checks++;
      if (mem_en !== me || (me && mem_addr !== AW'(ma))) begin
        errors++;
        $display("FAIL inflight_fetch_%0d got en=%b addr=%h exp en=%b addr=%h", i, mem_en,
                 mem_addr, me, AW'(ma));
      end
      if (i == 12) begin
        checks++;
        if (pixel !== init_ram[BASE][7:0]) begin
          errors++;
          $display("FAIL first_pixel_after_drop got %h exp %h", pixel, init_ram[BASE][7:0]);
        end
      end
      if (i == 13) begin
        checks++;
        if (pixel !== init_ram[BASE][15:8]) begin
          errors++;
          $display("FAIL second_pixel_after_drop got %h exp %h", pixel, init_ram[BASE][15:8]);
        end
      end
    end
  endtask

  task automatic test_underrun();
    step();
    y = 16'd0; xy_in_active = 1'b0;
    sample();
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_clear_before got %b exp 0", underrun);
    end
    step();
    y = 16'(YA);
    sample();
    step();
    y = 16'd0; xy_in_active = 1'b1;
    sample();
    step();
    xy_in_active = 1'b0;
    sample();
    checks++;
    if (pixel !== 8'h00 || underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_hit got pixel=%h underrun=%b exp 00 1", pixel, underrun);
    end
    for (int i = 0; i < 12; i++) begin
      step();
      y = (i < 3) ? 16'(YA) : 16'd0;
      sample();
    end
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_sticky got %b exp 1", underrun);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (underrun !== 1'b0 || pixel !== 8'h00) begin
      errors++;
      $display("FAIL underrun_reset got underrun=%b pixel=%h exp 0 00", underrun, pixel);
    end
    repeat (2) @(posedge pixel_clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) init_ram[i] = 32'h0;
    init_ram[BASE]     = 32'h44332211;
    init_ram[BASE + 1] = 32'h88776655;
    test_reset();
    test_resync_prefetch();
    test_pixel_serialise();
    test_cpu_access();
    test_full_frame();
    test_resync_inflight();
    test_underrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_scanout_arbiter.md
Name: vga_scanout_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM (32-bit words, 1-cycle read latency) between VGA scanout and a CPU bus port.
- Sits between the VGA location generator (consumes its x/y/xy_in_active/hsync/vsync/blank) and the RAM.
- Prefetches scanout words into a 2-word FIFO with strict priority, and serialises 8bpp pixels.
- Grants all remaining RAM slots to the CPU.

Parameters:
- X_ACTIVE, 800, active pixels per line; must be a multiple of 4.
- Y_ACTIVE, 600, active lines per frame.
- ADDR_W, 17, RAM word-address width.
- FB_BASE, 0, word address of pixel (0,0); the frame is contiguous at X_ACTIVE/4 words per line.

Ports:
- pixel_clock  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- x  in  16  current x from the location generator.
- y  in  16  current y from the location generator.
- xy_in_active  in  1  current pixel is in the active area.
- hsync_in, vsync_in, blank_in  in  1 each  timing from the location generator.
- hsync, vsync, blank  out  1 each  timing inputs delayed 1 cycle, aligned with pixel.
- pixel  out  8  current pixel value.
- underrun  out  1  sticky flag; cleared only by reset.
- cpu_valid  in  1  CPU request.
- cpu_ready  out  1  CPU request accepted this cycle.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_we  in  4  CPU byte write enables; 0 means read.
- cpu_wdata  in  32  CPU write data.
- cpu_rdata  out  32  CPU read data.
- cpu_rvalid  out  1  cpu_rdata valid.
- mem_addr  out  ADDR_W  RAM address.
- mem_en  out  1  RAM access this cycle.
- mem_we  out  4  RAM byte write enables.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty; fetch_addr=FB_BASE; byte_idx=0; no read in flight.
  - pixel=0; hsync=vsync=blank=0; underrun=0; cpu_rvalid=0; cpu_rdata=0.
- Vblank detect: vb = (y >= Y_ACTIVE), registered as vb_q. On the first cycle with vb && !vb_q (frame resync):
  - Flush the FIFO and set byte_idx=0 and fetch_addr=FB_BASE.
  - Tag any in-flight scanout read to be discarded.
  - No scanout fetch is issued in this cycle.
- Scanout fetch request: sreq = (fifo_count + scan_inflight < 2) && !resync.
- Arbitration (combinational, same cycle):
  - If sreq: mem_en=1, mem_we=0, mem_addr=fetch_addr; cpu_ready=0; fetch_addr advances next edge.
  - fetch_addr advances by +1, wrapping to FB_BASE after FB_BASE + X_ACTIVE/4*Y_ACTIVE - 1.
  - Otherwise cpu_ready=1 and mem_* mirror cpu_* gated by cpu_valid (mem_en=cpu_valid).
- CPU handshake:
  - Transfer occurs when cpu_valid && cpu_ready. The CPU must hold valid/addr/data until ready.
  - For a read (cpu_we==0): cpu_rvalid=1 exactly 1 cycle after the transfer, with cpu_rdata=mem_rdata registered that cycle (no extra latency).
  - A write produces no response.
  - cpu_rdata holds its last value when cpu_rvalid=0.
- Read return: a 1-bit tag registered with each read routes mem_rdata to the FIFO (scanout) or the CPU. A discarded scanout read is dropped.
- Pixel path, 1-cycle latency from the input-side xy_in_active:
  - If xy_in_active and FIFO non-empty: pixel <= head[8*byte_idx+7 : 8*byte_idx]; byte_idx <= byte_idx+1 mod 4; pop head when byte_idx==3.
  - If xy_in_active and FIFO empty: pixel <= 0; underrun <= 1; byte_idx still advances; no pop. Alignment is recovered at the next resync.
  - If not active: pixel <= 0; byte_idx unchanged.
  - hsync/vsync/blank <= their _in values every cycle.
- A FIFO push and pop in the same cycle leaves the count unchanged. A push is never issued when it would exceed depth 2.
- Bandwidth:
  - Steady-state scanout uses at most 1 slot in 4 during the active area and none once the FIFO is full.
  - During blanking the CPU gets every slot except up to 2 prefetches.
  - Underrun is impossible if the location generator is legal; the flag exists for verification.

Test Plan:
- Reset, then drive vb for 4 cycles with cpu_valid=0 → exactly 2 reads to FB_BASE and FB_BASE+1 on the cycles after resync; then mem_en=0.
- Preload word FB_BASE=0x44332211, FB_BASE+1=0x88776655; drive xy_in_active for 8 cycles → pixel = 11,22,33,44,55,66,77,88 on the following 8 cycles; the refill read of FB_BASE+2 is issued the cycle after the first pop; underrun=0.
- cpu_valid held high with a write to addr 5 (we=4'b1111, data 0xDEADBEEF) while the FIFO is refilling → cpu_ready=0 on the sreq cycle, 1 the next; then a read of addr 5 → cpu_rvalid and cpu_rdata=0xDEADBEEF one cycle after the grant.
- Full 800x600 frame with CPU requests every cycle → no underrun; fetch_addr wraps to FB_BASE at 120000 words; the CPU is granted on ≥75% of active-area cycles.
- Assert vb while a scanout read is in flight → the returned data is not pushed; the FIFO refills from FB_BASE; the first pixel of the next frame equals byte 0 of FB_BASE.
- Force underrun (FIFO empty with xy_in_active=1 via a stalled memory model) → pixel=0 and underrun=1, sticky across frames until reset_n=0.
